mbed_spi_scheduler: RTL and testbench
=====================================

// Module: mbed_spi_scheduler
// PURPOSE
//  Sequences the 32-bit MBED SPI master: arbitrates N_REQ word producers round-robin, waits for MBED ready,
//  holds the master enable for one transfer, detects its FIN edge, acks the winner. Sits between capture
//  logic and the SPI master; replaces switch/key-driven enable and clock.
// PARAMETERS
//  WIDTH        32    SPI word width (matches master outBits)
//  N_REQ        2     number of requesters
//  TIMEOUT      4096  max cycles from WAIT_RDY entry to FIN before abort
//  SYNC_STAGES  2     synchroniser depth for MBED_RDY
// PORTS
//  SYS_CLK      in   1            40 MHz system clock
//  RST          in   1            synchronous, active-high reset
//  REQ          in   N_REQ        level request per producer
//  REQ_DATA     in   N_REQ*WIDTH  word per producer, slice i = requester i
//  ACK          out  N_REQ        one-cycle pulse to requester whose word was sent
//  MBED_RDY     in   1            asynchronous ready from MBED GPIO
//  SPI_ENA      out  1            enable to SPI master, high for whole transfer
//  SPI_DATA     out  WIDTH        word to SPI master DATA_MOSI
//  SPI_FIN      in   1            master finished flag, synchronous to SYS_CLK
//  BUSY         out  1            high in any state other than IDLE
//  TIMEOUT_ERR  out  1            sticky abort flag
//  ERR_CLR      in   1            clears TIMEOUT_ERR
//  LAST_GNT     out  $clog2(N_REQ) index of most recent grant
// BEHAVIOUR
//  Reset: SPI_ENA=0, SPI_DATA=0, ACK=0, BUSY=0, TIMEOUT_ERR=0, LAST_GNT=N_REQ-1 (req 0 first), state IDLE.
//  RST mid-transfer: everything above restored at that edge; no ACK issued.
//  rdy_s = MBED_RDY after SYNC_STAGES flops. fin_rise = SPI_FIN & ~fin_q (fin_q: one register).
//  IDLE: any REQ -> winner = first set bit scanning LAST_GNT+1 upward, wrapping modulo N_REQ;
//        latch SPI_DATA <= winner slice, gnt <= winner, clear timeout counter; -> WAIT_RDY.
//  WAIT_RDY: rdy_s=1 -> SHIFT with SPI_ENA=1 next cycle. Timeout counter increments.
//  SHIFT: SPI_ENA=1; fin_rise -> DONE, SPI_ENA=0 next cycle. Counter increments.
//  DONE: ACK[gnt]=1 for exactly this cycle, LAST_GNT <= gnt; -> IDLE.
//  Timeout: counter == TIMEOUT-1 in WAIT_RDY/SHIFT -> IDLE, SPI_ENA=0, TIMEOUT_ERR=1, LAST_GNT <= gnt,
//        no ACK; requester retries when it next wins (no starvation of others).
//  fin_rise and timeout in same cycle: fin_rise wins (ACK issued, no error).
//  ERR_CLR with new timeout in same cycle: set wins.
//  Latency: REQ seen in IDLE at cycle t, rdy_s already 1 -> SPI_ENA high at t+2.
//  SPI_DATA stable from WAIT_RDY entry through DONE; REQ_DATA changes after latch ignored.
//  REQ deasserted mid-transfer: transfer completes, ACK still pulsed.
//  Min spacing: DONE + IDLE = 2 cycles between SPI_ENA low and next WAIT_RDY entry.
//  rdy_s dropping during SHIFT: ignored; only FIN or timeout end a transfer.
//  Timeout counter width $clog2(TIMEOUT)+1; saturates, never wraps.
// STRUCTURE
//  Package mbed_spi_pkg: state enum {IDLE, WAIT_RDY, SHIFT, DONE}, WIDTH and TIMEOUT defaults.
//  Sub-module rr_arbiter (REQ, LAST_GNT -> winner index, any_req), combinational, N_REQ-generic.
//  Top: synchroniser, FIN edge detect, FSM, timeout counter, data/grant registers.
// TESTING
//  1 REQ=2'b01, REQ_DATA[31:0]=32'hFAAFEBBE, MBED_RDY=1 -> SPI_ENA high t+2, SPI_DATA=FAAFEBBE,
//    FIN pulse -> ACK=2'b01 one cycle, LAST_GNT=0.
//  2 REQ=2'b11 held, FIN after each 40 cycles -> ACK order 01,10,01,10; SPI_DATA alternates slices.
//  3 MBED_RDY=0, REQ=2'b10, TIMEOUT=16 -> BUSY 16 cycles, TIMEOUT_ERR=1, ACK=0, SPI_ENA never high;
//    ERR_CLR pulse -> TIMEOUT_ERR=0.
//  4 RST asserted 5 cycles into SHIFT -> SPI_ENA=0, BUSY=0, LAST_GNT=1 next cycle, no ACK.
//  5 SPI_FIN held high 10 cycles in SHIFT -> exactly one ACK; FIN rising on timeout cycle -> ACK, no ERR.
//  6 REQ dropped and REQ_DATA changed during SHIFT -> SPI_DATA unchanged, ACK still pulsed.

Source files
------------

// File: rtl/mbed_spi_pkg.sv
// Shared types and defaults for the MBED SPI transfer scheduler.
package mbed_spi_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_N_REQ       = 2;
    localparam int DEF_TIMEOUT     = 4096;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Index width that stays legal when there is a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_gnt, wrapping modulo N_REQ.
module rr_arbiter
    import mbed_spi_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int GW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_gnt,
    output logic [GW-1:0]    winner,
    output logic             any_req
);

    logic [N_REQ-1:0] rot_req;
    logic [GW-1:0]    rot_idx [N_REQ];

    // rot_idx[k] is the requester at scan offset k+1 after the previous grant.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_idx[gi] = GW'((int'(last_gnt) + 1 + gi) % N_REQ);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner  = last_gnt;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                winner  = rot_idx[k];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbed_spi_scheduler.sv
// Arbitrates word producers onto the MBED SPI master: waits for MBED ready, holds SPI_ENA
// for one transfer, ends on the FIN rising edge or a timeout, then acks the winner.
module mbed_spi_scheduler
    import mbed_spi_pkg::*;
#(
    parameter int   WIDTH       = DEF_WIDTH,
    parameter int   N_REQ       = DEF_N_REQ,
    parameter int   TIMEOUT     = DEF_TIMEOUT,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int  GW          = idx_w(N_REQ)
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] REQ_DATA,
    output logic [N_REQ-1:0]       ACK,
    input  logic                   MBED_RDY,
    output logic                   SPI_ENA,
    output logic [WIDTH-1:0]       SPI_DATA,
    input  logic                   SPI_FIN,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR,
    input  logic                   ERR_CLR,
    output logic [GW-1:0]          LAST_GNT
);

    localparam int              CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   GNT_INIT = GW'(N_REQ - 1);

    state_t           state_reg;
    logic             rdy_sync_reg [SYNC_STAGES];
    logic             rdy_s;
    logic             fin_q_reg;
    logic             fin_rise;
    logic [CW-1:0]    cnt_reg;
    logic [GW-1:0]    gnt_reg;
    logic [GW-1:0]    last_gnt_reg;
    logic [GW-1:0]    winner;
    logic             any_req;
    logic [WIDTH-1:0] spi_data_reg;
    logic [N_REQ-1:0] ack_reg;
    logic             spi_ena_reg;
    logic             err_reg;
    logic             timeout_hit;
    logic [WIDTH-1:0] req_word [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_word
            assign req_word[gi] = REQ_DATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // MBED_RDY comes straight from a GPIO pin, so it crosses in through a flop chain.
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge SYS_CLK) begin
                    if (RST) rdy_sync_reg[gi] <= 1'b0;
                    else     rdy_sync_reg[gi] <= MBED_RDY;
                end
            end else begin : g_next
                always_ff @(posedge SYS_CLK) begin
                    if (RST) rdy_sync_reg[gi] <= 1'b0;
                    else     rdy_sync_reg[gi] <= rdy_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rdy_s    = rdy_sync_reg[SYNC_STAGES-1];
    assign fin_rise = SPI_FIN & ~fin_q_reg;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_arb (
        .req      (REQ),
        .last_gnt (last_gnt_reg),
        .winner   (winner),
        .any_req  (any_req)
    );

    // A FIN edge on the final counted cycle still completes the transfer.
    assign timeout_hit = (cnt_reg == CNT_LAST) &&
                         ((state_reg == WAIT_RDY) || ((state_reg == SHIFT) && !fin_rise));

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            fin_q_reg    <= 1'b0;
            cnt_reg      <= '0;
            gnt_reg      <= GNT_INIT;
            last_gnt_reg <= GNT_INIT;
            spi_data_reg <= '0;
            ack_reg      <= '0;
            spi_ena_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            fin_q_reg <= SPI_FIN;
            ack_reg   <= '0;

            if ((state_reg == WAIT_RDY || state_reg == SHIFT) && (cnt_reg != '1))
                cnt_reg <= cnt_reg + CW'(1);

            if (timeout_hit)
                err_reg <= 1'b1;
            else if (ERR_CLR)
                err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        spi_data_reg <= req_word[winner];
                        gnt_reg      <= winner;
                        cnt_reg      <= '0;
                        state_reg    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (timeout_hit) begin
                        last_gnt_reg <= gnt_reg;
                        state_reg    <= IDLE;
                    end else if (rdy_s) begin
                        spi_ena_reg <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Ready dropping mid-transfer is deliberately ignored here.
                    if (fin_rise) begin
                        spi_ena_reg      <= 1'b0;
                        ack_reg[gnt_reg] <= 1'b1;
                        state_reg        <= DONE;
                    end else if (timeout_hit) begin
                        spi_ena_reg  <= 1'b0;
                        last_gnt_reg <= gnt_reg;
                        state_reg    <= IDLE;
                    end
                end
                DONE: begin
                    last_gnt_reg <= gnt_reg;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ACK         = ack_reg;
    assign SPI_ENA     = spi_ena_reg;
    assign SPI_DATA    = spi_data_reg;
    assign BUSY        = (state_reg != IDLE);
    assign TIMEOUT_ERR = err_reg;
    assign LAST_GNT    = last_gnt_reg;

endmodule

// File: tb/tb_mbed_spi_scheduler.sv
// Directed bench for mbed_spi_scheduler with a transaction-level scoreboard checked every cycle.
module tb_mbed_spi_scheduler;

    localparam int WIDTH       = 32;
    localparam int N_REQ       = 2;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    logic                   clk = 1'b0;
    logic                   RST = 1'b1;
    logic [N_REQ-1:0]       REQ = '0;
    logic [N_REQ*WIDTH-1:0] REQ_DATA = '0;
    logic [N_REQ-1:0]       ACK;
    logic                   MBED_RDY = 1'b1;
    logic                   SPI_ENA;
    logic [WIDTH-1:0]       SPI_DATA;
    logic                   SPI_FIN = 1'b0;
    logic                   BUSY;
    logic                   TIMEOUT_ERR;
    logic                   ERR_CLR = 1'b0;
    logic                   LAST_GNT;

    int checks = 0;
    int errors = 0;
    int ack_cnt [N_REQ];

    always #5 clk = ~clk;

    mbed_spi_scheduler #(
        .WIDTH       (WIDTH),
        .N_REQ       (N_REQ),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .SYS_CLK     (clk),
        .RST         (RST),
        .REQ         (REQ),
        .REQ_DATA    (REQ_DATA),
        .ACK         (ACK),
        .MBED_RDY    (MBED_RDY),
        .SPI_ENA     (SPI_ENA),
        .SPI_DATA    (SPI_DATA),
        .SPI_FIN     (SPI_FIN),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ERR_CLR     (ERR_CLR),
        .LAST_GNT    (LAST_GNT)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ena(input string name, input int maxc);
        int n;
        n = 0;
        while (SPI_ENA !== 1'b1 && n < maxc) begin
            cyc(1);
            n++;
        end
        chk(name, SPI_ENA, 1);
    endtask

    // Round-robin rule: first set request after the last grant, wrapping.
    function automatic int rr_pick(input logic [N_REQ-1:0] req, input int last);
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (last + i) % N_REQ;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    // Scoreboard state, sampled 1 time unit after every rising edge.
    int               m_last = N_REQ - 1;
    int               m_gnt = 0;
    int               busy_len = 0;
    logic [WIDTH-1:0] m_data = '0;
    bit               m_err = 1'b0;
    bit               prev_busy = 1'b0;
    bit               prev_ena = 1'b0;
    bit               prev_ack = 1'b0;
    bit               prev_fin = 1'b0;
    bit               rdy_h1 = 1'b0;
    bit               rdy_h2 = 1'b0;
    logic [N_REQ-1:0] exp_ack;
    bit               timeout_now;

    always @(posedge clk) begin
        #1;
        if (RST) begin
            chk("rst_busy", BUSY, 0);
            chk("rst_ena", SPI_ENA, 0);
            chk("rst_ack", ACK, 0);
            chk("rst_data", SPI_DATA, 0);
            chk("rst_err", TIMEOUT_ERR, 0);
            chk("rst_last_gnt", LAST_GNT, N_REQ - 1);
            m_last   = N_REQ - 1;
            m_err    = 1'b0;
            busy_len = 0;
        end else begin
            exp_ack = '0;
            if (prev_ena && SPI_FIN && !prev_fin) exp_ack[m_gnt] = 1'b1;
            timeout_now = prev_busy && !BUSY && !prev_ack;

            if (!prev_busy) begin
                chk("idle_start", BUSY, |REQ);
                if (BUSY && REQ != '0) begin
                    m_gnt    = rr_pick(REQ, m_last);
                    m_data   = REQ_DATA[m_gnt*WIDTH +: WIDTH];
                    busy_len = 0;
                end
            end
            if (prev_ack) chk("idle_after_ack", BUSY, 0);

            chk("ack", ACK, exp_ack);
            if (exp_ack != '0) begin
                m_last = m_gnt;
                chk("ena_in_done", SPI_ENA, 0);
            end

            if (timeout_now) begin
                chk("timeout_len", busy_len, TIMEOUT);
                m_last = m_gnt;
                m_err  = 1'b1;
            end else if (ERR_CLR) begin
                m_err = 1'b0;
            end
            chk("err", TIMEOUT_ERR, m_err);

            if (BUSY) begin
                busy_len++;
                chk("data_hold", SPI_DATA, m_data);
                if (busy_len > TIMEOUT) chk("busy_bound", ACK != '0, 1);
            end else begin
                chk("last_gnt", LAST_GNT, m_last);
                chk("ena_idle", SPI_ENA, 0);
                busy_len = 0;
            end

            if (SPI_ENA && !prev_ena) chk("ena_needs_rdy", rdy_h2, 1);
            if (prev_ena && !SPI_ENA) chk("ena_drop", (ACK != '0) || !BUSY, 1);
        end

        for (int i = 0; i < N_REQ; i++) if (ACK[i] === 1'b1) ack_cnt[i]++;
        prev_busy = (BUSY === 1'b1);
        prev_ena  = (SPI_ENA === 1'b1);
        prev_ack  = (ACK !== '0);
        prev_fin  = SPI_FIN;
        rdy_h2    = rdy_h1;
        rdy_h1    = MBED_RDY;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base0, base1, n;
        bit ena_seen;

        cyc(3);
        chk("reset_busy", BUSY, 0);
        chk("reset_last_gnt", LAST_GNT, 1);
        chk("reset_ena", SPI_ENA, 0);
        RST = 1'b0;
        cyc(2);

        // 1: single request, ready already high
        REQ_DATA = {32'h12345678, 32'hFAAFEBBE};
        REQ      = 2'b01;
        cyc(1);
        chk("t1_busy", BUSY, 1);
        chk("t1_ena_early", SPI_ENA, 0);
        cyc(1);
        chk("t1_ena_t2", SPI_ENA, 1);
        chk("t1_data", SPI_DATA, 32'hFAAFEBBE);
        cyc(3);
        SPI_FIN = 1'b1;
        cyc(1);
        chk("t1_ack", ACK, 2'b01);
        SPI_FIN = 1'b0;
        REQ     = 2'b00;
        cyc(1);
        chk("t1_ack_one_cycle", ACK, 2'b00);
        chk("t1_last_gnt", LAST_GNT, 0);

        // 2: both requesting from reset, alternating grants
        RST = 1'b1;
        cyc(2);
        RST      = 1'b0;
        base0    = ack_cnt[0];
        base1    = ack_cnt[1];
        REQ_DATA = {32'hB1B1B1B1, 32'hA0A0A0A0};
        REQ      = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_ena("t2_ena", 20);
            chk("t2_data", SPI_DATA, (t % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            cyc(40);
            SPI_FIN = 1'b1;
            cyc(1);
            chk("t2_ack", ACK, (t % 2 == 0) ? 2'b01 : 2'b10);
            SPI_FIN = 1'b0;
        end
        REQ = 2'b00;
        cyc(3);
        chk("t2_acks0", ack_cnt[0] - base0, 2);
        chk("t2_acks1", ack_cnt[1] - base1, 2);

        // 3: ready never arrives; clear held high so the set/clear collision is exercised
        MBED_RDY = 1'b0;
        ERR_CLR  = 1'b1;
        cyc(3);
        base0    = ack_cnt[0];
        base1    = ack_cnt[1];
        REQ      = 2'b10;
        n        = 0;
        ena_seen = 1'b0;
        cyc(1);
        while (BUSY === 1'b1 && n < 200) begin
            n++;
            if (SPI_ENA === 1'b1) ena_seen = 1'b1;
            cyc(1);
        end
        REQ = 2'b00;
        chk("t3_busy_cycles", n, TIMEOUT);
        chk("t3_ena_never", ena_seen, 0);
        chk("t3_err_set_wins", TIMEOUT_ERR, 1);
        chk("t3_no_ack", (ack_cnt[0] - base0) + (ack_cnt[1] - base1), 0);
        chk("t3_last_gnt", LAST_GNT, 1);
        ERR_CLR = 1'b0;
        cyc(3);
        chk("t3_err_sticky", TIMEOUT_ERR, 1);
        ERR_CLR = 1'b1;
        cyc(1);
        chk("t3_err_clr", TIMEOUT_ERR, 0);
        ERR_CLR = 1'b0;

        // 4: reset five cycles into SHIFT
        MBED_RDY = 1'b1;
        cyc(3);
        REQ = 2'b01;
        wait_ena("t4_ena", 10);
        cyc(4);
        base0 = ack_cnt[0];
        RST   = 1'b1;
        cyc(1);
        chk("t4_ena", SPI_ENA, 0);
        chk("t4_busy", BUSY, 0);
        chk("t4_last_gnt", LAST_GNT, 1);
        chk("t4_ack", ACK, 0);
        RST = 1'b0;
        REQ = 2'b00;
        cyc(2);
        chk("t4_no_ack", ack_cnt[0] - base0, 0);

        // 5a: FIN held high for ten cycles
        REQ = 2'b01;
        wait_ena("t5_ena", 10);
        base0 = ack_cnt[0];
        cyc(2);
        SPI_FIN = 1'b1;
        cyc(1);
        chk("t5_ack", ACK, 2'b01);
        REQ = 2'b00;
        cyc(9);
        SPI_FIN = 1'b0;
        cyc(2);
        chk("t5_single_ack", ack_cnt[0] - base0, 1);

        // 5b: FIN rises on the very cycle the timeout would fire
        REQ = 2'b10;
        cyc(1);
        chk("t5b_busy", BUSY, 1);
        cyc(TIMEOUT - 1);
        chk("t5b_still_shift", SPI_ENA, 1);
        SPI_FIN = 1'b1;
        cyc(1);
        chk("t5b_ack", ACK, 2'b10);
        chk("t5b_no_err", TIMEOUT_ERR, 0);
        SPI_FIN = 1'b0;
        REQ     = 2'b00;
        cyc(2);

        // 6: request dropped and data changed after the latch
        REQ_DATA = {32'hCAFEF00D, 32'h0BADF00D};
        REQ      = 2'b10;
        wait_ena("t6_ena", 10);
        REQ      = 2'b00;
        REQ_DATA = {2{32'hDEADBEEF}};
        cyc(3);
        chk("t6_data", SPI_DATA, 32'hCAFEF00D);
        SPI_FIN = 1'b1;
        cyc(1);
        chk("t6_ack", ACK, 2'b10);
        chk("t6_data_done", SPI_DATA, 32'hCAFEF00D);
        SPI_FIN = 1'b0;
        cyc(3);
        chk("t6_last_gnt", LAST_GNT, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
